// File: rtl/sm3_msg_expand_if.sv
// rtl/sm3_msg_expand_if.sv - word-in / round-out stream bundle for sm3_msg_expand
interface sm3_msg_expand_if;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] w;
  logic [31:0] w1;
  logic [5:0]  round;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;

  // slave: the expansion block itself
  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, w, w1, round, dout_valid, dout_last
  );

  // master: block producer on the input side, round consumer on the output side
  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, w, w1, round, dout_valid, dout_last
  );
endinterface

// File: rtl/sm3_msg_expand.sv
// rtl/sm3_msg_expand.sv - SM3 message expansion, 16-word sliding window (option: SM3_MSG_LE_SWAP_EN)
module sm3_msg_expand #(
  parameter int ROUNDS = 64
) (
  input logic             clk,
  input logic             rst_n,
  sm3_msg_expand_if.slave bus
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  round_q;
  logic [31:0] win_q [16];
  logic        din_ready_q;
  logic        dout_valid_q;
  logic [31:0] din_word;
  logic [31:0] w_new_d;

  function automatic logic [31:0] rotl7(input logic [31:0] x);
    return {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] rotl15(input logic [31:0] x);
    return {x[16:0], x[31:17]};
  endfunction

  function automatic logic [31:0] rotl23(input logic [31:0] x);
    return {x[8:0], x[31:9]};
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl15(x) ^ rotl23(x);
  endfunction

`ifdef SM3_MSG_LE_SWAP_EN
  // little-endian producers: reverse bytes so the window always holds big-endian words
  assign din_word = {bus.din[7:0], bus.din[15:8], bus.din[23:16], bus.din[31:24]};
`else
  assign din_word = bus.din;
`endif

  // next expansion word W_{j+16} from the current window (win_q[0] = W_j)
  always_comb begin
    w_new_d = p1(win_q[0] ^ win_q[7] ^ rotl15(win_q[13])) ^ rotl7(win_q[3]) ^ win_q[10];
  end

  // load/run controller: fills the window, then shifts it once per accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      cnt_q        <= 4'd0;
      round_q      <= 6'd0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.din_valid && din_ready_q) begin
            win_q[cnt_q] <= din_word;
            cnt_q        <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q      <= ST_RUN;
              round_q      <= 6'd0;
              din_ready_q  <= 1'b0;
              dout_valid_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (dout_valid_q && bus.dout_ready) begin
            for (int i = 0; i < 15; i++) begin
              win_q[i] <= win_q[i+1];
            end
            win_q[15] <= w_new_d;
            if (round_q == LAST_ROUND) begin
              state_q      <= ST_LOAD;
              round_q      <= 6'd0;
              cnt_q        <= 4'd0;
              din_ready_q  <= 1'b1;
              dout_valid_q <= 1'b0;
            end else begin
              round_q <= round_q + 6'd1;
            end
          end
        end
        default: begin
          state_q      <= ST_LOAD;
          cnt_q        <= 4'd0;
          round_q      <= 6'd0;
          din_ready_q  <= 1'b1;
          dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready  = din_ready_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.w          = win_q[0];
  assign bus.w1         = win_q[0] ^ win_q[4];
  assign bus.round      = round_q;
  assign bus.dout_last  = dout_valid_q & (round_q == LAST_ROUND);

endmodule
